pixel_gen_pipe: RTL
===================

Name: pixel_gen_pipe

Overview:
- Parametrised, pipelined successor to the framebuffer pixel generator.
- Holds a dual-port iteration-count framebuffer:
  - Port A is written by the Mandelbrot compute engine.
  - Port B is read in raster order by the VGA timing logic.
- Maps each stored count to RGB through a selectable colour mode.
- Delays video_on, hsync and vsync so they stay aligned with the colour output at the VGA pins.

Parameters:
- DATA_W, 7: bits per stored iteration count.
- H_RES, 640: active pixels per line.
- V_RES, 480: active lines per frame.
- ADDR_W, 19: framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- RD_LAT, 2: framebuffer read latency in cycles, 1..3.
- COLOR_W, 12: output colour width, 4 bits per channel; must be 12.

Ports:
- CLK_100MHz, in, 1: sole clock.
- reset, in, 1: synchronous, active-high reset.
- video_on, in, 1: active-video flag from VGA timing.
- hsync_in, in, 1: horizontal sync from timing.
- vsync_in, in, 1: vertical sync from timing.
- pixel_x, in, 10: current column.
- pixel_y, in, 10: current row.
- wea, in, 1: framebuffer write enable.
- addr_w, in, ADDR_W: write address.
- dina, in, DATA_W: iteration count to write.
- mode, in, 2: colour mode request.
- color, out, COLOR_W: RGB {R[3:0],G[3:0],B[3:0]}.
- video_on_out, out, 1: delayed video_on.
- hsync_out, out, 1: delayed hsync_in.
- vsync_out, out, 1: delayed vsync_in.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high.
  - While reset is high, all pipeline registers clear: color=0, video_on_out=0, hsync_out=0, vsync_out=0, active mode=0.
  - Framebuffer contents are not cleared by reset.
- Pipeline, total latency L = RD_LAT+2 cycles from inputs to outputs:
  - S0: register rd_addr = pixel_y*H_RES + pixel_x, plus a valid flag. valid = video_on and pixel_x<H_RES and pixel_y<V_RES. When valid=0, rd_addr=0.
  - S1..S(RD_LAT): framebuffer read.
  - Final stage: colour map, registered.
- Sideband alignment:
  - video_on, hsync and vsync pass through an L-deep shift register.
  - The valid flag travels in parallel with them.
  - Invalid pixels output color=12'h000.
- Framebuffer:
  - H_RES*V_RES words of DATA_W bits.
  - Simultaneous write and read to the same address: the read returns the old data (read-first).
  - addr_w >= H_RES*V_RES: the write is ignored.
- Colour mode latch:
  - mode is sampled into active_mode only at frame start, defined as S0 seeing pixel_x==0 and pixel_y==0.
  - A mid-frame change of mode has no visible effect until the next frame.
- Colour map, with d = stored count and INSIDE = (d == all ones):
  - Mode 0, grey: R=G=B=d[DATA_W-1 -: 4]. INSIDE outputs 000.
  - Mode 1, raw/legacy: color = zero-extended d.
  - Mode 2, gradient, evaluated on the top 6 bits t = d[DATA_W-1 -: 6]:
    - t<32: B=0, R=t[4:1], G=15-t[4:1].
    - t>=32: R=15, G=t[4:1], B=t[4:1].
    - INSIDE outputs 000.
  - Mode 3, inverted grey: bitwise complement of mode 0. INSIDE outputs FFF.
- Reset mid-frame:
  - Outputs are 0 during reset.
  - After reset releases, the first L cycles output color=0 because the pipeline valid bits are cleared.

Optional Feature:
- Macro: PIXEL_GEN_CROSSHAIR_EN.
- When defined:
  - Adds input ports cursor_x[9:0] and cursor_y[9:0], sampled at frame start.
  - Any valid pixel with pixel_x==cursor_x or pixel_y==cursor_y outputs 12'hFFF, overriding the colour map.
  - The override applies at the same pipeline stage as the colour map, so latency is unchanged.
- When undefined: no cursor ports and no overlay logic.

Test Plan:
- Write 7'h7F at address 0 and 7'h40 at address 641; mode=0; scan the frame.
  - Pixel (0,0) outputs 000.
  - Pixel (1,1) outputs 888, exactly RD_LAT+2 cycles after pixel_x=1 and pixel_y=1 are presented.
- Mode=1 with d=7'h15 → color=12'h015.
- Mode=2 with d=7'h20 → 12'h870.
- Mode=2 with d=7'h50 → 12'hF44.
- Change mode from 0 to 3 at pixel (100,200): colour stays mode 0 until the next (0,0); the first pixel of the next frame reflects mode 3.
- video_on=0, or pixel_x=700: color=000 at the aligned output cycle. Check that hsync_out and vsync_out equal the inputs delayed by exactly L.
- Assert reset for 1 cycle mid-line: all outputs are 0 the next cycle and stay 0 for L cycles after release; then the framebuffer data still reads back unchanged.
- Crosshair build (PIXEL_GEN_CROSSHAIR_EN defined), cursor=(10,20): all of row 20 and column 10 output FFF; pixel (11,21) shows the mapped colour.

Source files
------------

// File: rtl/pixel_gen_pipe.sv
// pixel_gen_pipe: pipelined framebuffer-to-VGA pixel generator with selectable colour modes
// Ports: CLK_100MHz/reset (synchronous, active-high); video_on, hsync_in, vsync_in, pixel_x, pixel_y
//   from VGA timing; wea/addr_w/dina framebuffer write port (compute engine); mode colour mode request,
//   latched at frame start; color {R,G,B} plus video_on_out/hsync_out/vsync_out, all aligned
//   L = RD_LAT+2 cycles after the inputs.
// Optional: define PIXEL_GEN_CROSSHAIR_EN to add cursor_x/cursor_y inputs and a white crosshair overlay.
module pixel_gen_pipe #(
  parameter int DATA_W  = 7,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int RD_LAT  = 2,
  parameter int COLOR_W = 12
) (
  input  logic               CLK_100MHz,
  input  logic               reset,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               wea,
  input  logic [ADDR_W-1:0]  addr_w,
  input  logic [DATA_W-1:0]  dina,
  input  logic [1:0]         mode,
`ifdef PIXEL_GEN_CROSSHAIR_EN
  input  logic [9:0]         cursor_x,
  input  logic [9:0]         cursor_y,
`endif
  output logic [COLOR_W-1:0] color,
  output logic               video_on_out,
  output logic               hsync_out,
  output logic               vsync_out
);
  localparam int L     = RD_LAT + 2;
  localparam int DEPTH = H_RES * V_RES;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q [RD_LAT];
  logic [ADDR_W-1:0] rd_addr;
  logic [RD_LAT:0]   v_p;
  logic [1:0]        m_p [RD_LAT+1];
  logic [2:0]        sb [L];
  logic [1:0]        active_mode, cur_mode;
  logic              sof, valid, ovr;
  assign sof      = pixel_x == 10'd0 && pixel_y == 10'd0;
  assign valid    = video_on && 32'(pixel_x) < H_RES && 32'(pixel_y) < V_RES;
  // the frame-start pixel itself already uses the newly requested mode
  assign cur_mode = sof ? mode : active_mode;
  assign {video_on_out, hsync_out, vsync_out} = sb[L-1];
  function automatic logic [COLOR_W-1:0] cmap(input logic [1:0] m, input logic [DATA_W-1:0] d);
    logic [3:0] g, t;
    logic [COLOR_W-1:0] grey;
    g    = d[DATA_W-1 -: 4];
    t    = d[DATA_W-2 -: 4];  // bits [4:1] of the top-6 gradient index
    grey = &d ? '0 : {g, g, g};
    return m == 2'd0 ? grey :
           m == 2'd1 ? COLOR_W'(d) :
           m == 2'd3 ? ~grey :
           &d ? '0 : d[DATA_W-1] ? {4'hF, t, t} : {t, ~t, 4'h0};
  endfunction
  // framebuffer: no reset so it maps onto block RAM; nonblocking read gives read-first behaviour
  always_ff @(posedge CLK_100MHz) begin
    if (wea && 32'(addr_w) < DEPTH) mem[addr_w] <= dina;
    rd_q[0] <= mem[rd_addr];
    for (int i = 1; i < RD_LAT; i++) rd_q[i] <= rd_q[i-1];
  end
`ifdef PIXEL_GEN_CROSSHAIR_EN
  logic [9:0]      cur_x, cur_y, cx, cy;
  logic [RD_LAT:0] h_p;
  assign cx  = sof ? cursor_x : cur_x;
  assign cy  = sof ? cursor_y : cur_y;
  assign ovr = h_p[RD_LAT];
  always_ff @(posedge CLK_100MHz) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
      h_p   <= '0;
    end else begin
      cur_x <= cx;
      cur_y <= cy;
      h_p   <= {h_p[RD_LAT-1:0], pixel_x == cx || pixel_y == cy};
    end
  end
`else
  assign ovr = 1'b0;
`endif
  always_ff @(posedge CLK_100MHz) begin
    if (reset) begin
      rd_addr     <= '0;
      v_p         <= '0;
      active_mode <= '0;
      color       <= '0;
      for (int i = 0; i <= RD_LAT; i++) m_p[i] <= '0;
      for (int i = 0; i < L; i++) sb[i] <= '0;
    end else begin
      rd_addr     <= valid ? ADDR_W'(pixel_y) * ADDR_W'(H_RES) + ADDR_W'(pixel_x) : '0;
      v_p         <= {v_p[RD_LAT-1:0], valid};
      active_mode <= cur_mode;
      m_p[0]      <= cur_mode;
      for (int i = 1; i <= RD_LAT; i++) m_p[i] <= m_p[i-1];
      sb[0]       <= {video_on, hsync_in, vsync_in};
      for (int i = 1; i < L; i++) sb[i] <= sb[i-1];
      color       <= !v_p[RD_LAT] ? '0 : ovr ? '1 : cmap(m_p[RD_LAT], rd_q[RD_LAT-1]);
    end
  end
endmodule
